ssd_scan_mux: RTL
=================

// Module: ssd_scan_mux
// PURPOSE
//   Time-multiplexed driver for a two-digit seven-segment display. Sits directly downstream
//   of the counter/decoder stage: it consumes the 14-bit two-digit segment word (num) and
//   drives one shared 7-bit segment bus plus two digit enables.
//   - Snapshots num once per frame so both digits in a frame come from the same count.
//   - Inserts a blanking gap before each digit to prevent ghosting.
// PARAMETERS
//   REFRESH_DIV    50000  clk cycles per digit slot, including blanking (1 kHz slot at 50 MHz); must be >= 2
//   BLANK_CYCLES   500    cycles at the start of each slot with all digits off; must be < REFRESH_DIV
//   SEG_ACTIVE_LOW 1      1: segment and digit-enable outputs are active-low; 0: active-high
// PORTS
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous, active-low reset
//   num         in   14  segment patterns: [6:0] = digit 0, [13:7] = digit 1 (already in SEG_ACTIVE_LOW polarity)
//   seg         out  7   shared segment bus, registered
//   dig_en      out  2   digit enables, [0] = digit 0, [1] = digit 1, registered
//   frame_tick  out  1   one-cycle pulse marking the end of each complete frame
//   dim         in   2   brightness step; present only when SSD_DIM_EN is defined
// BEHAVIOUR
//   - Reset: one clock, asynchronous active-low rst_n.
//     - Assertion forces the following immediately, regardless of clk:
//       FSM = BLANK0, slot counter = 0, shadow = OFF pattern, seg = OFF, dig_en = OFF, frame_tick = 0.
//     - OFF = 7'h7F / 2'b11 when SEG_ACTIVE_LOW=1; 7'h00 / 2'b00 otherwise.
//     - On release, the scan restarts from BLANK0. There is no partial-frame resume after reset mid-operation.
//   - Slot counter: width $clog2(REFRESH_DIV). Counts 0..REFRESH_DIV-1, then wraps to 0.
//     The FSM advances only on a wrap.
//   - FSM: BLANK0 -> SHOW0 -> BLANK1 -> SHOW1 -> BLANK0.
//     - Each BLANKx state lasts BLANK_CYCLES cycles.
//     - Each SHOWx state lasts REFRESH_DIV-BLANK_CYCLES cycles.
//     - Each BLANK+SHOW pair is one slot.
//     - Implementation: a 2-bit digit index plus the counter compare (cnt < BLANK_CYCLES => blank phase).
//   - Snapshot: shadow <= num on the single cycle where the FSM enters BLANK0 (slot 0, cnt==0).
//     - num changes during a frame are ignored until the next frame.
//     - The first frame after reset shows OFF; the first capture occurs at the first wrap back to BLANK0.
//   - Outputs are registered, with exactly one cycle latency from the internal state:
//     - blank phase: seg = OFF, dig_en = OFF.
//     - SHOW0: seg = shadow[6:0], dig_en = digit 0 active only.
//     - SHOW1: seg = shadow[13:7], dig_en = digit 1 active only.
//     - Never more than one digit is active in any cycle.
//   - frame_tick: registered; high for exactly one cycle, on the cycle after the last SHOW1 cycle
//     (coincident with the first BLANK0 output cycle).
//   - Frame period = 2*REFRESH_DIV cycles, exactly, in steady state.
// CONFIGURATION
//   SSD_DIM_EN defined:
//     - The dim[1:0] port exists. Within each SHOW phase, let S = REFRESH_DIV-BLANK_CYCLES:
//       the digit is enabled only for the first S*(4-dim)/4 cycles, then seg/dig_en = OFF for the rest of the slot.
//     - dim=0 gives full brightness; dim=3 gives 25%. Integer division truncates.
//     - dim is sampled at each slot start and held for that slot.
//   SSD_DIM_EN undefined:
//     - The dim port is absent and behaviour is full duty (identical to dim=0).
// TESTING  (bench params REFRESH_DIV=8, BLANK_CYCLES=2, SEG_ACTIVE_LOW=1 unless noted)
//   1. Reset: assert rst_n=0 mid-SHOW1 -> seg=7'h7F, dig_en=2'b11, frame_tick=0 with no clk edge;
//      release -> 2 blank cycles, then SHOW0.
//   2. Steady scan: num=14'h0040 held -> per 16-cycle frame: 2 cyc OFF, 6 cyc seg=7'h40 dig_en=2'b10,
//      2 cyc OFF, 6 cyc seg=7'h00 dig_en=2'b01; frame_tick every 16 cycles.
//   3. Snapshot: change num during SHOW0 -> current frame's SHOW1 still shows the old digit 1;
//      new values appear from the next frame.
//   4. One-hot check: random num every cycle for 1000 frames ->
//      dig_en is never 2'b00, and seg=7'h7F whenever dig_en=2'b11.
//   5. SSD_DIM_EN, dim=2 -> each SHOW phase enables its digit for 3 cycles, then OFF for 3 cycles;
//      dim changed mid-slot takes effect at the next slot.
//   6. SEG_ACTIVE_LOW=0 -> reset gives seg=7'h00, dig_en=2'b00; SHOW0 drives dig_en=2'b01.

Source files
------------

// File: rtl/ssd_scan_mux.sv
// -----------------------------------------------------------------------------
// ssd_scan_mux
//
// Time-multiplexed driver for a two-digit seven-segment display. It sits
// directly behind the counter/decoder stage, takes the 14-bit two-digit segment
// word and drives one shared 7-bit segment bus plus two digit enables.
//
// A frame is two slots of REFRESH_DIV cycles each. Every slot opens with
// BLANK_CYCLES cycles with all digits off (anti-ghosting gap) and then shows one
// digit for the rest of the slot:
//
//   BLANK0 -> SHOW0 -> BLANK1 -> SHOW1 -> BLANK0 ...
//
// The input word is copied into a shadow register once per frame, on the wrap
// into BLANK0, so both digits of one frame always come from the same count.
// The first frame after reset therefore shows the OFF pattern.
//
// Parameters
//   REFRESH_DIV    clk cycles per digit slot, blanking included (>= 2)
//   BLANK_CYCLES   blank cycles at the start of each slot (< REFRESH_DIV)
//   SEG_ACTIVE_LOW 1: seg/dig_en are active-low, 0: active-high
//
// Ports
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous, active-low reset
//   num         in   14  [6:0] = digit 0 pattern, [13:7] = digit 1 pattern,
//                        already in the output polarity
//   dim         in   2   brightness step (only with SSD_DIM_EN)
//   seg         out  7   shared segment bus, registered
//   dig_en      out  2   digit enables, [0] = digit 0, [1] = digit 1, registered
//   frame_tick  out  1   one-cycle pulse on the first BLANK0 output cycle that
//                        follows a complete frame
//
// Optional feature
//   SSD_DIM_EN  when defined, adds the dim port. Within each SHOW phase of
//               S = REFRESH_DIV-BLANK_CYCLES cycles the digit is lit only for
//               the first S*(4-dim)/4 cycles (truncating). dim is sampled at
//               the start of each slot and held for that slot. When undefined,
//               the digit is lit for the whole SHOW phase.
// -----------------------------------------------------------------------------
module ssd_scan_mux #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] num,
`ifdef SSD_DIM_EN
    input  logic [1:0]  dim,
`endif
    output logic [6:0]  seg,
    output logic [1:0]  dig_en,
    output logic        frame_tick
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int            CW          = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST    = CW'(REFRESH_DIV - 1);
    localparam int            SHOW_CYCLES = REFRESH_DIV - BLANK_CYCLES;

    localparam logic [6:0]  SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]  DIG_OFF    = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;
    localparam logic [1:0]  DIG0_ON    = SEG_ACTIVE_LOW ? 2'b10 : 2'b01;
    localparam logic [1:0]  DIG1_ON    = SEG_ACTIVE_LOW ? 2'b01 : 2'b10;
    localparam logic [13:0] SHADOW_OFF = {SEG_OFF, SEG_OFF};

    // FSM encoding: {digit index, show phase}. The state is derived from the
    // digit index register and the blank-phase compare on the slot counter.
    localparam logic [1:0] ST_BLANK0 = 2'b00;
    localparam logic [1:0] ST_SHOW0  = 2'b01;
    localparam logic [1:0] ST_BLANK1 = 2'b10;
    localparam logic [1:0] ST_SHOW1  = 2'b11;

    // First counter value at which the digit goes dark again for a given
    // brightness step; dim=0 keeps it lit to the end of the slot.
    function automatic int lit_end(input logic [1:0] step);
        return BLANK_CYCLES + (SHOW_CYCLES * (4 - int'(step))) / 4;
    endfunction

    // ------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt;        // position within the current slot
    logic [1:0]    dig_idx;    // slot index within the frame: 0 or 1
    logic [13:0]   shadow;     // frame snapshot of num
    logic          frame_end;  // set while the FSM sits in the first BLANK0
                               // cycle after a completed frame

    logic          wrap;
    logic          slot_start;
    logic          last_slot;
    logic [31:0]   cnt_ext;
    logic          blank_phase;
    logic          lit;
    int            lit_limit;
    logic [1:0]    state;
    logic [6:0]    seg_nxt;
    logic [1:0]    dig_nxt;

    assign wrap       = (cnt == CNT_LAST);
    assign slot_start = (cnt == '0);
    assign last_slot  = (dig_idx == 2'd1);
    assign cnt_ext    = 32'(cnt);

`ifdef SSD_DIM_EN
    logic [1:0] dim_hold;
    logic [1:0] dim_eff;

    // dim is latched on the first cycle of the slot; on that cycle itself
    // the live input is used so the whole slot sees one consistent value.
    assign dim_eff   = slot_start ? dim : dim_hold;
    assign lit_limit = lit_end(dim_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dim_hold <= 2'd0;
        end else if (slot_start) begin
            dim_hold <= dim;
        end
    end
`else
    assign lit_limit = lit_end(2'd0);
`endif

    assign blank_phase = (cnt_ext < 32'(BLANK_CYCLES));
    assign lit         = (cnt_ext < 32'(lit_limit));
    assign state       = {dig_idx[0], ~blank_phase};

    // ------------------------------------------------------------------
    // Slot counter and digit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            dig_idx <= 2'd0;
        end else if (wrap) begin
            cnt     <= '0;
            dig_idx <= last_slot ? 2'd0 : dig_idx + 2'd1;
        end else begin
            cnt     <= cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame snapshot and end-of-frame marker
    // ------------------------------------------------------------------
    // The capture happens on the edge that moves the FSM from the last SHOW1
    // cycle into BLANK0, so the state right after reset (already BLANK0)
    // does not capture and the first frame shows the OFF pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= SHADOW_OFF;
            frame_end <= 1'b0;
        end else begin
            frame_end <= wrap && last_slot;
            if (wrap && last_slot) begin
                shadow <= num;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        seg_nxt = SEG_OFF;
        dig_nxt = DIG_OFF;
        case (state)
            ST_SHOW0: begin
                if (lit) begin
                    seg_nxt = shadow[6:0];
                    dig_nxt = DIG0_ON;
                end
            end
            ST_SHOW1: begin
                if (lit) begin
                    seg_nxt = shadow[13:7];
                    dig_nxt = DIG1_ON;
                end
            end
            ST_BLANK0, ST_BLANK1: begin
                seg_nxt = SEG_OFF;
                dig_nxt = DIG_OFF;
            end
            default: begin
                seg_nxt = SEG_OFF;
                dig_nxt = DIG_OFF;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers: one cycle behind the internal state. frame_end is
    // itself one cycle behind the wrap, so frame_tick lands on the same
    // cycle as the first BLANK0 output.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_OFF;
            dig_en     <= DIG_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_nxt;
            dig_en     <= dig_nxt;
            frame_tick <= frame_end;
        end
    end

endmodule
